// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder streamed through one 4-bit lookahead slice, LS nibble first.
// Optional subtract mode via `define NIBBLE_SERIAL_SUB_EN.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NL = WIDTH / 4;
    localparam int IW = NL > 1 ? $clog2(NL) : 1;

    generate
        if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state;
    logic [WIDTH-1:0] ra, rb;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [3:0]      p, g, s;
    logic [4:0]      c;
    logic            sub_i;

`ifdef NIBBLE_SERIAL_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    // Operands shift right each RUN cycle, so the active nibble is always bits [3:0].
    always_comb begin
        p    = ra[3:0] ^ rb[3:0];
        g    = ra[3:0] & rb[3:0];
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ra       <= '0;
            rb       <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra    <= a;
                    rb    <= b ^ {WIDTH{sub_i}};
                    carry <= cin ^ sub_i;
                    sum   <= '0;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum[4*idx +: 4] <= s;
                    carry           <= c[4];
                    ra              <= ra >> 4;
                    rb              <= rb >> 4;
                    if (idx == IW'(NL - 1)) begin
                        cout     <= c[4];
                        overflow <= c[3] ^ c[4];
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-word binary adder that streams two WIDTH-bit operands through a single 4-bit carry-lookahead slice, one nibble per clock, least-significant nibble first. It sits directly around the 4-bit lookahead stage: it feeds each nibble pair and the registered carry into the slice and consumes the slice's sum and carry-out. This trades latency for area on wide datapaths. Operands arrive and results leave over valid/ready handshakes.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, ≥ 4; any other value is an elaboration error.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand set a, b, cin is present.
- in_ready  output  1  block accepts operands; high only in IDLE.
- a  input  WIDTH  addend.
- b  input  WIDTH  addend.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  result sum, cout, overflow are valid; high only in DONE.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  registered sum.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed two's-complement overflow, equal to the carry into the MSB XOR cout.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a and b into shift registers, load the carry register with cin, clear sum to 0, set the nibble index to 0, and go to RUN.
- RUN:
  - Each cycle, feed nibble[idx] of a and b plus the carry register into the 4-bit lookahead slice.
  - At the edge: write the slice's sum into sum[4*idx+3:4*idx], load the slice's carry-out into the carry register, and increment idx.
  - On the last nibble (idx = WIDTH/4−1), also capture cout and overflow (carry into bit WIDTH−1 XOR carry-out), then go to DONE.
- DONE:
  - out_valid = 1. sum, cout and overflow hold stable.
  - On out_valid & out_ready, go to IDLE.
- Only one operation is in flight. in_valid is ignored outside IDLE, and operands may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH. cout is the true (WIDTH+1)-th bit of a + b + cin.

## Timing
- Reset values: out_valid 0, sum 0, cout 0, overflow 0, carry register 0, idx 0. in_ready is 1, because it decodes IDLE.
- Latency: for an acceptance edge E, out_valid rises after edge E + WIDTH/4. With WIDTH = 16 this is 4 cycles.
- Result is handed off at the edge where out_valid & out_ready. in_ready is high in the following cycle.
- Best-case throughput is one operation per WIDTH/4 + 2 cycles (accept cycle, WIDTH/4 RUN cycles, DONE cycle).
- out_ready held high on entry to DONE: the handshake completes after exactly one DONE cycle.
- out_ready low: DONE persists indefinitely with the outputs frozen.
- Reset asserted mid-RUN or mid-DONE: the block returns to IDLE immediately (asynchronously) with the reset values, and the partial result is discarded.
- idx wraps to 0 only on acceptance, never by overflow.

## Configuration
- NIBBLE_SERIAL_SUB_EN defined:
  - Adds an input port sub (1 bit), sampled at acceptance.
  - sub = 1: the b register is loaded with ~b and the carry register with ~cin, so the result is a − b − cin (cin acts as borrow-in). cout = 0 indicates a borrow-out. overflow reports signed subtraction overflow.
  - sub = 0: the block behaves as the plain adder.
- Macro undefined: there is no sub port, and the block is an adder only.

## Test plan
- WIDTH = 16, a = 0xFFFF, b = 0x0001, cin = 0 -> sum 0x0000, cout 1, overflow 0; out_valid rises 4 cycles after the accept edge.
- a = 0x7FFF, b = 0x0001, cin = 0 -> sum 0x8000, cout 0, overflow 1. Then a = 0x1234, b = 0x4321, cin = 1 -> sum 0x5556, cout 0, overflow 0.
- Backpressure: out_ready low for 5 cycles in DONE while in_valid pulses with new operands -> sum, cout and overflow stay frozen, in_ready stays 0, the new operands are ignored, and the result is released on the first out_ready-high edge.
- Reset mid-operation: rst_n pulled low 2 cycles into RUN -> outputs go to their reset values immediately. After release, a = 0x00FF, b = 0x0F01, cin = 0 gives sum 0x1000, cout 0.
- Back-to-back: in_valid and out_ready held high with a random operand stream -> one result every 6 cycles, each matching a + b + cin computed to 17 bits.
- With NIBBLE_SERIAL_SUB_EN: sub = 1, a = 0x0005, b = 0x0007, cin = 0 -> sum 0xFFFE, cout 0 (borrow), overflow 0. Then sub = 1, a = 0x8000, b = 0x0001, cin = 0 -> sum 0x7FFF, cout 1, overflow 1.
